// File: rtl/round_timer.sv
// Game round countdown timer: 1 Hz prescaler plus a seconds counter with start/pause/expiry control.
// Optional bonus-seconds input is enabled by defining BONUS_TIME_EN.
module round_timer #(
  parameter int unsigned CLK_HZ        = 100000000,
  parameter int unsigned ROUND_SECONDS = 30
`ifdef BONUS_TIME_EN
  , parameter int unsigned BONUS_SECONDS = 3
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause_toggle,
`ifdef BONUS_TIME_EN
  input  logic       add_time,
`endif
  output logic [5:0] time_remaining,
  output logic       running,
  output logic       expired,
  output logic       timed_out
);

  localparam int unsigned PW      = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [5:0]  RELOAD  = 6'(ROUND_SECONDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_PAUSED,
    S_EXPIRED
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    time_q, time_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          timed_out_q, timed_out_d;
  logic          tick;
  logic          dec;
  logic [5:0]    upd_time;
`ifdef BONUS_TIME_EN
  logic          add_req;
  logic [6:0]    sum7;
`endif

  // Seconds value after this cycle's tick and/or bonus, used in RUNNING and PAUSED.
  always_comb begin
    tick = (state_q == S_RUNNING) && (pre_q == PRE_MAX);
    dec  = tick && (time_q != 6'd0);
`ifdef BONUS_TIME_EN
    add_req  = add_time && !start && ((state_q == S_RUNNING) || (state_q == S_PAUSED));
    sum7     = 7'(time_q) + (add_req ? 7'(BONUS_SECONDS) : 7'd0) - (dec ? 7'd1 : 7'd0);
    upd_time = (sum7 > 7'd63) ? 6'd63 : sum7[5:0];
`else
    upd_time = dec ? (time_q - 6'd1) : time_q;
`endif
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    time_d    = time_q;
    expired_d = 1'b0;
    if (start) begin
      state_d = S_RUNNING;
      pre_d   = '0;
      time_d  = RELOAD;
    end else begin
      case (state_q)
        S_RUNNING: begin
          pre_d  = tick ? '0 : (pre_q + PW'(1));
          time_d = upd_time;
          // Reaching zero ends the round even if a pause arrives on the same edge.
          if (tick && (upd_time == 6'd0)) begin
            state_d   = S_EXPIRED;
            expired_d = 1'b1;
          end else if (pause_toggle) begin
            state_d = S_PAUSED;
          end
        end
        S_PAUSED: begin
          time_d = upd_time;
          if (pause_toggle) begin
            state_d = S_RUNNING;
          end
        end
        default: begin
        end
      endcase
    end
    running_d   = (state_d == S_RUNNING);
    timed_out_d = (state_d == S_EXPIRED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      time_q      <= RELOAD;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      time_q      <= time_d;
      running_q   <= running_d;
      expired_q   <= expired_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign time_remaining = time_q;
  assign running        = running_q;
  assign expired        = expired_q;
  assign timed_out      = timed_out_q;

endmodule
